// File: rtl/wb_reg_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-register bridge.
package wb_reg_bridge_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_t;

    localparam logic [31:0] ERR_RDATA = 32'h0;

    // Wide enough for the largest allowed TIMEOUT_CYCLES (255).
    localparam int unsigned TMO_CNT_W = 8;

endpackage

// File: rtl/wb_reg_bridge_tmo.sv
// ACCESS-state cycle counter; flags expiry after TIMEOUT_CYCLES cycles without completion.
module wb_reg_bridge_tmo
    import wb_reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    output logic expired
);

    localparam logic [TMO_CNT_W-1:0] Limit = TMO_CNT_W'(TIMEOUT_CYCLES);

    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;

    assign expired = active && (cnt_q == Limit);

    // Held at zero outside ACCESS, so every entry starts a fresh count.
    always_comb begin
        cnt_d = '0;
        if (active) begin
            cnt_d = expired ? cnt_q : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_reg_bridge.sv
// Wishbone classic slave to simple register-responder bridge (IDLE -> ACCESS -> RESP).
// Optional access timeout with error response: define WB_REG_BRIDGE_TIMEOUT_EN.
module wb_reg_bridge
    import wb_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W         = 6,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_cyc,
    input  logic              i_wb_stb,
    input  logic              i_wb_we,
    input  logic [ADDR_W-1:0] i_wb_adr,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic [31:0]       o_wb_dat,
    output logic              o_wb_ack,
    output logic              o_wb_err,
    output logic [ADDR_W-1:0] o_reg_adr,
    output logic [31:0]       o_reg_wdata,
    output logic [3:0]        o_reg_sel,
    output logic              o_reg_we,
    output logic              o_reg_re,
    input  logic [31:0]       i_reg_rdata,
    input  logic              i_reg_rdy
);

    state_t state_q, state_d;
    logic   we_q;
    logic   ack_q;
    logic   ack_d, err_d;
    logic   tmo_hit;

    // Strobes come from registered state only, so they drop the cycle after reset.
    assign o_reg_we = (state_q == StAccess) && we_q;
    assign o_reg_re = (state_q == StAccess) && !we_q;
    assign o_wb_ack = ack_q;

    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StIdle: begin
                if (i_wb_cyc && i_wb_stb) begin
                    state_d = StAccess;
                end
            end
            StAccess: begin
                // A dropped cycle wins: no termination even if the responder is ready.
                if (!i_wb_cyc) begin
                    state_d = StIdle;
                end else if (i_reg_rdy) begin
                    state_d = StResp;
                    ack_d   = 1'b1;
                end else if (tmo_hit) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            we_q        <= 1'b0;
            ack_q       <= 1'b0;
            o_wb_dat    <= '0;
            o_reg_adr   <= '0;
            o_reg_wdata <= '0;
            o_reg_sel   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            if (state_q == StIdle && i_wb_cyc && i_wb_stb) begin
                we_q        <= i_wb_we;
                o_reg_adr   <= i_wb_adr;
                o_reg_wdata <= i_wb_dat;
                o_reg_sel   <= i_wb_sel;
            end
            if (ack_d && !we_q) begin
                o_wb_dat <= i_reg_rdata;
            end else if (err_d) begin
                o_wb_dat <= ERR_RDATA;
            end
        end
    end

`ifdef WB_REG_BRIDGE_TIMEOUT_EN
    logic err_q;

    wb_reg_bridge_tmo #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_tmo (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .active (state_q == StAccess),
        .expired(tmo_hit)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_wb_err = err_q;
`else
    logic unused_tmo;

    assign unused_tmo = ^{TIMEOUT_CYCLES, err_d};
    assign tmo_hit    = 1'b0;
    assign o_wb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_wb_reg_bridge.sv
// Self-checking bench for wb_reg_bridge: vector table, corner sequences, random traffic.
module tb_wb_reg_bridge;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_wb_cyc, i_wb_stb, i_wb_we;
    logic [5:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic [31:0] o_wb_dat;
    logic        o_wb_ack, o_wb_err;
    logic [5:0]  o_reg_adr;
    logic [31:0] o_reg_wdata;
    logic [3:0]  o_reg_sel;
    logic        o_reg_we, o_reg_re;
    logic [31:0] i_reg_rdata;
    logic        i_reg_rdy;

    wb_reg_bridge #(
        .ADDR_W        (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_adr   (i_wb_adr),
        .i_wb_dat   (i_wb_dat),
        .i_wb_sel   (i_wb_sel),
        .o_wb_dat   (o_wb_dat),
        .o_wb_ack   (o_wb_ack),
        .o_wb_err   (o_wb_err),
        .o_reg_adr  (o_reg_adr),
        .o_reg_wdata(o_reg_wdata),
        .o_reg_sel  (o_reg_sel),
        .o_reg_we   (o_reg_we),
        .o_reg_re   (o_reg_re),
        .i_reg_rdata(i_reg_rdata),
        .i_reg_rdy  (i_reg_rdy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Background monitor: cycle numbers of ack pulses and count of write-strobe cycles.
    int cycle_no = 0;
    int ack_cyc_q[$];
    int we_cycles = 0;

    always @(posedge i_clk) cycle_no <= cycle_no + 1;

    always @(negedge i_clk) begin
        if (o_wb_ack) ack_cyc_q.push_back(cycle_no);
        if (o_reg_we) we_cycles <= we_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_cycle();
        next_cycle();
        i_wb_cyc  = 1'($urandom);
        i_wb_stb  = 1'b0;
        i_reg_rdy = 1'($urandom);
        @(negedge i_clk);
        check("idle_strobes", {30'd0, o_reg_we, o_reg_re}, 32'd0);
        check("idle_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
    endtask

    // One complete transaction: stb in cycle 0, responder ready after w wait cycles.
    // Expected behaviour: strobe for w+1 cycles with the latched fields, ack in cycle w+2.
    task automatic run_txn(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic [31:0] rdata, input int w,
                           input logic [31:0] exp_dat);
        next_cycle();
        i_wb_cyc    = 1'b1;
        i_wb_stb    = 1'b1;
        i_wb_we     = we;
        i_wb_adr    = adr;
        i_wb_dat    = dat;
        i_wb_sel    = sel;
        i_reg_rdy   = 1'($urandom);
        i_reg_rdata = $urandom;
        @(negedge i_clk);
        check("req_cycle_strobes", {30'd0, o_reg_we, o_reg_re}, 32'd0);
        for (int k = 1; k <= w + 2; k++) begin
            next_cycle();
            i_wb_stb    = 1'($urandom);
            i_wb_we     = 1'($urandom);
            i_wb_adr    = 6'($urandom);
            i_wb_dat    = $urandom;
            i_wb_sel    = 4'($urandom);
            i_reg_rdy   = (k - 1 >= w);
            i_reg_rdata = (k == w + 1) ? rdata : $urandom;
            @(negedge i_clk);
            if (k <= w + 1) begin
                check("access_we", {31'd0, o_reg_we}, {31'd0, we});
                check("access_re", {31'd0, o_reg_re}, {31'd0, !we});
                check("access_adr", {26'd0, o_reg_adr}, {26'd0, adr});
                check("access_wdata", o_reg_wdata, dat);
                check("access_sel", {28'd0, o_reg_sel}, {28'd0, sel});
                check("access_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
            end else begin
                check("resp_ack_err", {30'd0, o_wb_ack, o_wb_err}, 32'd2);
                check("resp_strobes", {30'd0, o_reg_we, o_reg_re}, 32'd0);
                check("resp_dat", o_wb_dat, exp_dat);
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [5:0]  adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] rdata;
        int          w;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] model_dat;
    int          ack_base, we_base, bad_gaps;

    initial begin
        vecs[0] = '{1'b1, 6'h3C, 32'h1234_5678, 4'hF, 32'hDEAD_BEEF, 0, 32'h0};
        vecs[1] = '{1'b0, 6'h24, 32'h0000_0000, 4'hF, 32'hCAFE_0001, 0, 32'hCAFE_0001};
        vecs[2] = '{1'b0, 6'h10, 32'h5555_AAAA, 4'h1, 32'h0BAD_F00D, 3, 32'h0BAD_F00D};
        vecs[3] = '{1'b1, 6'h08, 32'hA5A5_5A5A, 4'h3, 32'h1111_2222, 2, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 6'h3C, 32'h0000_0001, 4'hC, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF};
        vecs[5] = '{1'b1, 6'h00, 32'hFFFF_FFFF, 4'h0, 32'h7777_7777, 0, 32'hFFFF_FFFF};

        // Reset with the bus trying to start a transfer.
        i_rst_n = 1'b0; i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1;
        i_wb_adr = 6'h3F; i_wb_dat = 32'hFFFF_FFFF; i_wb_sel = 4'hF;
        i_reg_rdata = 32'hFFFF_FFFF; i_reg_rdy = 1'b1;
        repeat (3) next_cycle();
        @(negedge i_clk);
        check("rst_dat", o_wb_dat, 32'd0);
        check("rst_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
        check("rst_strobes", {30'd0, o_reg_we, o_reg_re}, 32'd0);
        check("rst_fields", {o_reg_adr, o_reg_sel} | o_reg_wdata, 32'd0);
        next_cycle();
        i_rst_n = 1'b1; i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        idle_cycle();

        foreach (vecs[i]) begin
            run_txn(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].rdata,
                    vecs[i].w, vecs[i].exp_dat);
        end
        model_dat = 32'hFFFF_FFFF;

`ifdef WB_REG_BRIDGE_TIMEOUT_EN
        // Responder never ready: err 17 cycles after ACCESS entry, data forced to zero.
        next_cycle();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 6'h14; i_reg_rdy = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            next_cycle();
            i_wb_stb    = 1'b0;
            i_reg_rdata = $urandom | 32'h1;
            @(negedge i_clk);
            if (k <= 17) begin
                check("tmo_wait_re", {31'd0, o_reg_re}, 32'd1);
                check("tmo_wait_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
            end else if (k == 18) begin
                check("tmo_err", {30'd0, o_wb_ack, o_wb_err}, 32'd1);
                check("tmo_dat", o_wb_dat, 32'd0);
                check("tmo_resp_re", {31'd0, o_reg_re}, 32'd0);
            end else begin
                check("tmo_after", {30'd0, o_wb_ack, o_wb_err, o_reg_re}, 32'd0);
            end
        end
        model_dat = 32'h0;
`else
        // Without the timeout the bridge waits as long as the responder needs.
        run_txn(1'b0, 6'h14, 32'h0, 4'hF, 32'h600D_CAFE, 40, 32'h600D_CAFE);
        model_dat = 32'h600D_CAFE;
`endif

        // Abort: cycle dropped in ACCESS returns to idle without termination.
        next_cycle();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_adr = 6'h2C; i_reg_rdy = 1'b0;
        next_cycle();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_reg_rdata = 32'h1357_9BDF;
        @(negedge i_clk);
        check("abort_access_re", {31'd0, o_reg_re}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            @(negedge i_clk);
            check("abort_no_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
            check("abort_idle", {30'd0, o_reg_we, o_reg_re}, 32'd0);
            check("abort_dat", o_wb_dat, model_dat);
        end

        // Reset in mid-ACCESS: everything zero the following cycle.
        next_cycle();
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 6'h3F;
        i_wb_dat = 32'h89AB_CDEF; i_wb_sel = 4'hF; i_reg_rdy = 1'b0;
        next_cycle();
        i_wb_stb = 1'b0;
        @(negedge i_clk);
        check("rst_mid_we_before", {31'd0, o_reg_we}, 32'd1);
        i_rst_n = 1'b0;
        next_cycle();
        i_rst_n = 1'b1; i_reg_rdy = 1'b1;
        @(negedge i_clk);
        check("rst_mid_term", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
        check("rst_mid_strobes", {30'd0, o_reg_we, o_reg_re}, 32'd0);
        check("rst_mid_fields", {o_reg_adr, o_reg_sel} | o_reg_wdata | o_wb_dat, 32'd0);
        next_cycle();
        @(negedge i_clk);
        check("rst_mid_no_ack", {30'd0, o_wb_ack, o_wb_err}, 32'd0);
        model_dat = 32'h0;
        i_wb_cyc = 1'b0;

        // Ten back-to-back writes, each with a zero-wait responder.
        ack_base = ack_cyc_q.size();
        we_base  = we_cycles;
        for (int i = 0; i < 10; i++) begin
            run_txn(1'b1, 6'(i * 4), 32'hB2B0_0000 + i, 4'hF, $urandom, 0, model_dat);
        end
        next_cycle();
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        @(negedge i_clk);
        check("b2b_acks", ack_cyc_q.size() - ack_base, 32'd10);
        check("b2b_commits", we_cycles - we_base, 32'd10);
        bad_gaps = 0;
        for (int i = ack_base + 1; i < ack_cyc_q.size(); i++) begin
            if (ack_cyc_q[i] - ack_cyc_q[i-1] != 3) bad_gaps++;
        end
        check("b2b_gap3", bad_gaps, 32'd0);

        // Random traffic against the transaction-level model.
        for (int n = 0; n < 200; n++) begin
            logic        we;
            logic [31:0] rd;
            we = 1'($urandom);
            rd = $urandom;
            if (!we) model_dat = rd;
            run_txn(we, 6'($urandom), $urandom, 4'($urandom), rd, int'($urandom_range(0, 4)),
                    model_dat);
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
